// File: rtl/stb_pkg.sv
// Shared types and constants for the stochastic-to-binary window accumulator.
// STB_BIPOLAR_EN selects the signed result encoding in stb_result_reg.
package stb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ACCUM
  } stb_state_t;

  localparam int STB_NW  = 8;
  localparam int STB_WIN = 1 << STB_NW;

endpackage

// File: rtl/stb_result_reg.sv
// Result holding register with valid/ready handshake and sticky overrun.
// Defining STB_BIPOLAR_EN converts the count to 2*count - 2^N_W.
module stb_result_reg
  import stb_pkg::*;
#(
  parameter int N_W = STB_NW
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           load,
  input  logic [N_W:0]   load_data,
  input  logic           start,
  input  logic           result_ready,
  output logic [N_W+1:0] result,
  output logic           result_valid,
  output logic           overrun
);

  logic [N_W+1:0] conv;

`ifdef STB_BIPOLAR_EN
  localparam logic [N_W+1:0] OFS = {2'b01, {N_W{1'b0}}};
  assign conv = {load_data, 1'b0} - OFS;
`else
  assign conv = {1'b0, load_data};
`endif

  logic lost;
  assign lost = load && result_valid && !result_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (load) begin
        result       <= conv;
        result_valid <= 1'b1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
      // a fresh loss outranks a simultaneous clear
      if (lost)
        overrun <= 1'b1;
      else if (start)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/stb_window_accum.sv
// Counts ones of a stochastic stream over one phase period, aligned to wrap.
// STB_BIPOLAR_EN (see stb_result_reg) selects signed output encoding.
module stb_window_accum
  import stb_pkg::*;
#(
  parameter int N_W = STB_NW
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [N_W-1:0] phase,
  input  logic           sbit,
  input  logic           start,
  input  logic           cont,
  output logic           busy,
  output logic [N_W+1:0] result,
  output logic           result_valid,
  input  logic           result_ready,
  output logic           overrun
);

  stb_state_t   state;
  logic [N_W:0] acc;
  logic [N_W:0] sum;
  logic         ph_zero;
  logic         ph_last;
  logic         load;

  assign ph_zero = (phase == '0);
  assign ph_last = &phase;
  assign sum     = acc + {{N_W{1'b0}}, sbit};
  assign load    = (state == ACCUM) && ph_last;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start)
            state <= ARM;
        end
        ARM: begin
          if (ph_zero) begin
            acc   <= {{N_W{1'b0}}, sbit};
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= sum;
          // next cycle is phase 0, so re-arming keeps windows gapless
          if (ph_last)
            state <= cont ? ARM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  stb_result_reg #(
    .N_W(N_W)
  ) u_res (
    .clk         (clk),
    .resetn      (resetn),
    .load        (load),
    .load_data   (sum),
    .start       (start),
    .result_ready(result_ready),
    .result      (result),
    .result_valid(result_valid),
    .overrun     (overrun)
  );

endmodule

// File: tb/tb_stb_window_accum.sv
// Randomized self-checking bench for stb_window_accum (N_W=8).
module tb_stb_window_accum;

  localparam int W   = 8;
  localparam int WIN = 256;

  logic         clk = 1'b0;
  logic         resetn;
  logic [W-1:0] phase;
  logic         sbit;
  logic         start;
  logic         cont;
  logic         busy;
  logic [W+1:0] result;
  logic         result_valid;
  logic         result_ready;
  logic         overrun;

  int  npass = 0;
  int  ntot  = 0;
  logic pat [WIN];

  always #5 clk = ~clk;

  stb_window_accum #(.N_W(W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .phase       (phase),
    .sbit        (sbit),
    .start       (start),
    .cont        (cont),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .overrun     (overrun)
  );

  function automatic logic [W+1:0] expv(input int c);
`ifdef STB_BIPOLAR_EN
    return 10'(2 * c - WIN);
`else
    return 10'(c);
`endif
  endfunction

  // one sample per cycle; outputs are read at the following negedge
  task automatic drive(input logic b);
    sbit = b;
    @(negedge clk);
    phase = phase + 1'b1;
    start = 1'b0;
  endtask

  task automatic go_phase(input int p);
    for (int i = 0; i < 2 * WIN && phase != W'(p); i++)
      drive(1'b0);
  endtask

  // model: the result of a window is simply the popcount of its samples
  task automatic make_pat(input int mode, output int cnt);
    int thr;
    thr = $urandom_range(0, 100);
    cnt = 0;
    for (int i = 0; i < WIN; i++) begin
      case (mode)
        0:       pat[i] = ($urandom % 100) < thr;
        1:       pat[i] = (i < 64);
        2:       pat[i] = 1'b1;
        default: pat[i] = 1'b0;
      endcase
      cnt += int'(pat[i]);
    end
  endtask

  task automatic drive_pat(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      drive(pat[i]);
  endtask

  task automatic arm_at(input int p);
    go_phase(p);
    start = 1'b1;
    drive(1'b0);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) drive(1'b1);
    ntot++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0d want 0", busy); else npass++;
    ntot++; if (result !== '0) $display("FAIL rst_result: got %0d want 0", result); else npass++;
    ntot++; if (result_valid !== 1'b0) $display("FAIL rst_valid: got %0d want 0", result_valid); else npass++;
    ntot++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %0d want 0", overrun); else npass++;
    resetn = 1'b1;
    repeat (4) drive(1'b1);
    ntot++; if (busy !== 1'b0) $display("FAIL idle_busy: got %0d want 0", busy); else npass++;
  endtask

  task automatic test_single_shot(input int mode);
    int c;
    cont = 1'b0;
    result_ready = 1'b1;
    make_pat(mode, c);
    arm_at($urandom_range(1, 200));
    ntot++; if (busy !== 1'b1) $display("FAIL ss_busy_rise: got %0d want 1", busy); else npass++;
    go_phase(0);
    drive_pat(0, WIN - 2);
    ntot++; if (result_valid !== 1'b0) $display("FAIL ss_early_valid: got %0d want 0", result_valid); else npass++;
    drive_pat(WIN - 1, WIN - 1);
    ntot++; if (result_valid !== 1'b1) $display("FAIL ss_valid: got %0d want 1", result_valid); else npass++;
    ntot++; if (result !== expv(c)) $display("FAIL ss_result: got %0d want %0d", result, expv(c)); else npass++;
    drive(1'b0);
    ntot++; if (result_valid !== 1'b0) $display("FAIL ss_valid_drop: got %0d want 0", result_valid); else npass++;
    ntot++; if (busy !== 1'b0) $display("FAIL ss_busy_fall: got %0d want 0", busy); else npass++;
  endtask

  task automatic test_cont_extremes;
    int c;
    int k;
    cont = 1'b1;
    result_ready = 1'b1;
    make_pat(2, c);
    arm_at(5);
    go_phase(0);
    drive_pat(0, WIN - 1);
    ntot++; if (result !== expv(WIN)) $display("FAIL cont_ones: got %0d want %0d", result, expv(WIN)); else npass++;
    ntot++; if (busy !== 1'b1) $display("FAIL cont_busy: got %0d want 1", busy); else npass++;
    cont = 1'b0;
    k = 0;
    do begin
      drive(1'b0);
      k++;
    end while (!result_valid && k < 600);
    ntot++; if (k !== WIN) $display("FAIL cont_spacing: got %0d want %0d", k, WIN); else npass++;
    ntot++; if (result !== expv(0)) $display("FAIL cont_zeros: got %0d want %0d", result, expv(0)); else npass++;
    drive(1'b0);
    ntot++; if (busy !== 1'b0) $display("FAIL cont_stop: got %0d want 0", busy); else npass++;
  endtask

  task automatic test_late_arm;
    cont = 1'b0;
    result_ready = 1'b1;
    go_phase(100);
    start = 1'b1;
    drive(1'b1);
    for (int i = 0; i < WIN && phase != '0; i++)
      drive(1'b1);
    ntot++; if (result_valid !== 1'b0) $display("FAIL late_no_early: got %0d want 0", result_valid); else npass++;
    repeat (WIN) drive(1'b0);
    ntot++; if (result_valid !== 1'b1) $display("FAIL late_valid: got %0d want 1", result_valid); else npass++;
    ntot++; if (result !== expv(0)) $display("FAIL late_result: got %0d want %0d", result, expv(0)); else npass++;
    drive(1'b0);
  endtask

  task automatic test_overrun;
    int c1;
    int c2;
    int c3;
    cont = 1'b1;
    result_ready = 1'b0;
    make_pat(0, c1);
    arm_at($urandom_range(1, 250));
    go_phase(0);
    drive_pat(0, WIN - 1);
    ntot++; if (result !== expv(c1)) $display("FAIL ovr_first: got %0d want %0d", result, expv(c1)); else npass++;
    ntot++; if (overrun !== 1'b0) $display("FAIL ovr_not_yet: got %0d want 0", overrun); else npass++;
    cont = 1'b0;
    make_pat(0, c2);
    drive_pat(0, WIN - 1);
    ntot++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %0d want 1", overrun); else npass++;
    ntot++; if (result !== expv(c2)) $display("FAIL ovr_second: got %0d want %0d", result, expv(c2)); else npass++;
    ntot++; if (result_valid !== 1'b1) $display("FAIL ovr_valid: got %0d want 1", result_valid); else npass++;
    repeat (3) drive(1'b0);
    ntot++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %0d want 1", overrun); else npass++;
    start = 1'b1;
    drive(1'b0);
    ntot++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %0d want 0", overrun); else npass++;
    ntot++; if (result !== expv(c2)) $display("FAIL ovr_hold: got %0d want %0d", result, expv(c2)); else npass++;
    result_ready = 1'b1;
    drive(1'b0);
    ntot++; if (result_valid !== 1'b0) $display("FAIL ovr_consume: got %0d want 0", result_valid); else npass++;
    make_pat(1, c3);
    go_phase(0);
    drive_pat(0, WIN - 1);
    ntot++; if (result !== expv(c3)) $display("FAIL ovr_rearm: got %0d want %0d", result, expv(c3)); else npass++;
    drive(1'b0);
  endtask

  task automatic test_ready_at_end;
    int c1;
    int c2;
    cont = 1'b0;
    result_ready = 1'b0;
    make_pat(0, c1);
    arm_at($urandom_range(1, 250));
    go_phase(0);
    drive_pat(0, WIN - 1);
    make_pat(0, c2);
    start = 1'b1;
    drive(1'b0);
    go_phase(0);
    drive_pat(0, WIN - 2);
    ntot++; if (result !== expv(c1)) $display("FAIL rdy_stable: got %0d want %0d", result, expv(c1)); else npass++;
    result_ready = 1'b1;
    drive_pat(WIN - 1, WIN - 1);
    result_ready = 1'b0;
    ntot++; if (result_valid !== 1'b1) $display("FAIL rdy_valid: got %0d want 1", result_valid); else npass++;
    ntot++; if (result !== expv(c2)) $display("FAIL rdy_result: got %0d want %0d", result, expv(c2)); else npass++;
    ntot++; if (overrun !== 1'b0) $display("FAIL rdy_overrun: got %0d want 0", overrun); else npass++;
    result_ready = 1'b1;
    drive(1'b0);
  endtask

  task automatic test_reset_mid;
    int c;
    logic seen;
    cont = 1'b0;
    result_ready = 1'b0;
    make_pat(2, c);
    arm_at(7);
    go_phase(0);
    drive_pat(0, WIN - 1);
    start = 1'b1;
    drive(1'b0);
    go_phase(0);
    for (int i = 0; i < 128; i++)
      drive(1'b1);
    sbit = 1'b1;
    #1 resetn = 1'b0;
    #1;
    ntot++; if (busy !== 1'b0) $display("FAIL mid_busy: got %0d want 0", busy); else npass++;
    ntot++; if (result !== '0) $display("FAIL mid_result: got %0d want 0", result); else npass++;
    ntot++; if (result_valid !== 1'b0) $display("FAIL mid_valid: got %0d want 0", result_valid); else npass++;
    @(negedge clk);
    phase = phase + 1'b1;
    resetn = 1'b1;
    result_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom));
      if (result_valid || busy) seen = 1'b1;
    end
    ntot++; if (seen !== 1'b0) $display("FAIL mid_no_result: got %0d want 0", seen); else npass++;
  endtask

  initial begin
    phase = '0;
    sbit = 1'b0;
    start = 1'b0;
    cont = 1'b0;
    result_ready = 1'b1;
    resetn = 1'b0;
    test_reset();
    test_single_shot(1);
    test_single_shot(0);
    test_single_shot(0);
    test_cont_extremes();
    test_late_arm();
    test_overrun();
    test_ready_at_end();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
